regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have these ports, clock and reset first: CLK in 1, rising-edge clock; Reset in 1, asynchronous active-high reset.
REQ-002 SHALL have ReqA_Valid in 1 (ALU write-back request), ReqA_Rd in 2 (destination register), ReqA_Data in 16 (write value), ReqA_Ready out 1 (A accepted this cycle).
REQ-003 SHALL have ReqB_Valid in 1, ReqB_Rd in 2, ReqB_Data in 16 and ReqB_Ready out 1, with the same meanings for the memory-load requester.
REQ-004 SHALL have register-file write outputs RegWrite out 1, Rd out 2 and WriteData out 16, all registered.
REQ-005 SHALL have read-hazard ports R1 in 2 and R2 in 2 (current read addresses), Stall out 1 (read hazard) and Busy out 1 (write activity outstanding).
REQ-006 SHALL be a single clock domain; reset is asynchronous and active-high.

Function
REQ-007 SHALL hold one pending entry per requester: PendA/PendB flag plus Rd and Data.
REQ-008 SHALL make the accept condition Valid && Ready, and on accept set the pending flag, capturing Rd and Data at that edge.
REQ-009 SHALL drive Ready_X = !Pend_X || Grant_X, combinationally, so a drained slot refills in the same cycle (one write per cycle per requester sustained).
REQ-010 SHALL compute grants combinationally: only PendA -> GrantA; only PendB -> GrantB; both -> grant the requester not granted last (round-robin); neither -> no grant.
REQ-011 SHALL keep the round-robin pointer LastGrant (1 bit) updated only on a grant; its reset value is B, so A wins the first contention.
REQ-012 SHALL, on a grant at edge N, register RegWrite=1, Rd=granted Rd and WriteData=granted Data, and clear the granted pending flag unless the same requester is accepted at edge N.
REQ-013 SHALL, with no grant, register RegWrite=0 and hold Rd and WriteData at their previous values.
REQ-014 SHALL have accept-to-RegWrite latency of exactly 1 cycle when uncontended (accept edge N, RegWrite high in cycle after N+1), so the register file writes at edge N+2.
REQ-015 SHALL delay a losing requester by 1 cycle per contention; under continuous contention grants alternate A,B,A,B; there is no starvation.
REQ-016 SHALL issue same-Rd writes from different requesters in grant order; per-requester write order is always preserved.
REQ-017 SHALL assert Stall combinationally when any valid Rd in {PendA, PendB, issued (RegWrite=1) stage} equals R1 or R2.
REQ-018 SHALL assert Busy = PendA || PendB || RegWrite.
REQ-019 SHALL never assert RegWrite for two requesters in the same cycle; at most one write per cycle.
REQ-020 SHALL ignore Valid when Ready=0; the requester must hold Rd and Data stable until accepted.

Reset
REQ-021 SHALL clear PendA, PendB, RegWrite, Rd, WriteData and Stall-source entries to 0 and set LastGrant=B immediately on Reset assertion, independent of CLK.
REQ-022 SHALL drive outputs during reset to RegWrite=0, Rd=0, WriteData=16'h0000, Busy=0, Stall=0, ReqA_Ready=1 and ReqB_Ready=1.
REQ-023 SHALL discard pending entries and any issued write on a mid-operation reset, and accept no request while Reset=1.

Verification
REQ-024 SHALL cover a single A write: ReqA Rd=2, Data=16'h1234 for 1 cycle -> next cycle RegWrite=1, Rd=2, WriteData=16'h1234 for exactly 1 cycle; Busy high 2 cycles.
REQ-025 SHALL cover simultaneous first requests: A(Rd=1, 16'h00AA) and B(Rd=3, 16'h00BB) in the same cycle after reset -> A issued first, B the next cycle; ReqB_Ready=0 for 1 cycle.
REQ-026 SHALL cover continuous contention: A and B held valid for 6 cycles with changing data -> issue order A,B,A,B,A,B, with no dropped or duplicated data.
REQ-027 SHALL cover the hazard case: pending B with Rd=0 and R1=0 -> Stall=1 until the cycle after RegWrite for Rd=0 drops; R1=1 with no matching entry -> Stall=0.
REQ-028 SHALL cover reset mid-operation: both pending, Reset pulsed between edges -> outputs zero immediately, no RegWrite afterward, and the first post-reset contention grants A.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
// Two requesters (A = ALU write-back, B = memory load) each own a one-entry
// pending slot. A single registered write port is shared round-robin between
// them, and a combinational read-hazard check covers every write not yet
// committed to the register file.
module regfile_write_arbiter (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        ReqA_Valid,
    input  logic [1:0]  ReqA_Rd,
    input  logic [15:0] ReqA_Data,
    output logic        ReqA_Ready,
    input  logic        ReqB_Valid,
    input  logic [1:0]  ReqB_Rd,
    input  logic [15:0] ReqB_Data,
    output logic        ReqB_Ready,
    output logic        RegWrite,
    output logic [1:0]  Rd,
    output logic [15:0] WriteData,
    input  logic [1:0]  R1,
    input  logic [1:0]  R2,
    output logic        Stall,
    output logic        Busy
);

    // Round-robin pointer encoding: which requester was granted most recently.
    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    // True when a valid write entry targets either current read address.
    function automatic logic rd_hit(input logic       valid,
                                    input logic [1:0] rd,
                                    input logic [1:0] r1,
                                    input logic [1:0] r2);
        return valid && ((rd == r1) || (rd == r2));
    endfunction

    // Pending slots
    logic        pend_a_q, pend_a_d;
    logic [1:0]  rd_a_q,   rd_a_d;
    logic [15:0] data_a_q, data_a_d;
    logic        pend_b_q, pend_b_d;
    logic [1:0]  rd_b_q,   rd_b_d;
    logic [15:0] data_b_q, data_b_d;

    // Arbitration and issue stage
    logic        last_grant_q, last_grant_d;
    logic        reg_write_q,  reg_write_d;
    logic [1:0]  rd_q,         rd_d;
    logic [15:0] wdata_q,      wdata_d;

    logic        grant_a_s;
    logic        grant_b_s;
    logic        accept_a_s;
    logic        accept_b_s;

    // Grant selection: a lone pending slot wins; on contention the requester
    // not granted last time wins, so neither side can starve.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        case ({pend_a_q, pend_b_q})
            2'b10: grant_a_s = 1'b1;
            2'b01: grant_b_s = 1'b1;
            2'b11: begin
                if (last_grant_q == GRANT_B) begin
                    grant_a_s = 1'b1;
                end else begin
                    grant_b_s = 1'b1;
                end
            end
            default: begin
                grant_a_s = 1'b0;
                grant_b_s = 1'b0;
            end
        endcase
    end

    // A slot is free when empty or when it drains this cycle, so a
    // requester can sustain one write per cycle.
    assign ReqA_Ready = !pend_a_q || grant_a_s;
    assign ReqB_Ready = !pend_b_q || grant_b_s;
    assign accept_a_s = ReqA_Valid && ReqA_Ready;
    assign accept_b_s = ReqB_Valid && ReqB_Ready;

    // Pending-slot next state: a new accept overrides the drain of the same slot.
    always_comb begin
        pend_a_d = pend_a_q;
        rd_a_d   = rd_a_q;
        data_a_d = data_a_q;
        pend_b_d = pend_b_q;
        rd_b_d   = rd_b_q;
        data_b_d = data_b_q;
        if (accept_a_s) begin
            pend_a_d = 1'b1;
            rd_a_d   = ReqA_Rd;
            data_a_d = ReqA_Data;
        end else if (grant_a_s) begin
            pend_a_d = 1'b0;
        end else begin
            pend_a_d = pend_a_q;
        end
        if (accept_b_s) begin
            pend_b_d = 1'b1;
            rd_b_d   = ReqB_Rd;
            data_b_d = ReqB_Data;
        end else if (grant_b_s) begin
            pend_b_d = 1'b0;
        end else begin
            pend_b_d = pend_b_q;
        end
    end

    // Issue-stage next state: the granted entry moves to the write port;
    // with no grant the address/data hold and only RegWrite drops.
    always_comb begin
        reg_write_d  = grant_a_s || grant_b_s;
        rd_d         = rd_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        if (grant_a_s) begin
            rd_d         = rd_a_q;
            wdata_d      = data_a_q;
            last_grant_d = GRANT_A;
        end else if (grant_b_s) begin
            rd_d         = rd_b_q;
            wdata_d      = data_b_q;
            last_grant_d = GRANT_B;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // State registers; reset discards pending and issued writes and points
    // the round-robin at B so A wins the first contention.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pend_a_q     <= 1'b0;
            rd_a_q       <= 2'd0;
            data_a_q     <= 16'h0000;
            pend_b_q     <= 1'b0;
            rd_b_q       <= 2'd0;
            data_b_q     <= 16'h0000;
            last_grant_q <= GRANT_B;
            reg_write_q  <= 1'b0;
            rd_q         <= 2'd0;
            wdata_q      <= 16'h0000;
        end else begin
            pend_a_q     <= pend_a_d;
            rd_a_q       <= rd_a_d;
            data_a_q     <= data_a_d;
            pend_b_q     <= pend_b_d;
            rd_b_q       <= rd_b_d;
            data_b_q     <= data_b_d;
            last_grant_q <= last_grant_d;
            reg_write_q  <= reg_write_d;
            rd_q         <= rd_d;
            wdata_q      <= wdata_d;
        end
    end

    assign RegWrite  = reg_write_q;
    assign Rd        = rd_q;
    assign WriteData = wdata_q;

    // A read must wait while any uncommitted write targets its address.
    assign Stall = rd_hit(pend_a_q,    rd_a_q, R1, R2) ||
                   rd_hit(pend_b_q,    rd_b_q, R1, R2) ||
                   rd_hit(reg_write_q, rd_q,   R1, R2);

    assign Busy = pend_a_q || pend_b_q || reg_write_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [1:0]  a_rd;
    logic [15:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [1:0]  b_rd;
    logic [15:0] b_data;
    logic        b_ready;
    logic        reg_write;
    logic [1:0]  rd;
    logic [15:0] wdata;
    logic [1:0]  r1;
    logic [1:0]  r2;
    logic        stall;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] got_data[$];
    logic [1:0]  got_rd[$];
    logic [15:0] exp_data[7];
    logic [1:0]  exp_rd[7];
    int          ia;
    int          ib;
    logic        ra;
    logic        rb;

    regfile_write_arbiter dut (
        .CLK        (clk),
        .Reset      (rst),
        .ReqA_Valid (a_valid),
        .ReqA_Rd    (a_rd),
        .ReqA_Data  (a_data),
        .ReqA_Ready (a_ready),
        .ReqB_Valid (b_valid),
        .ReqB_Rd    (b_rd),
        .ReqB_Data  (b_data),
        .ReqB_Ready (b_ready),
        .RegWrite   (reg_write),
        .Rd         (rd),
        .WriteData  (wdata),
        .R1         (r1),
        .R2         (r2),
        .Stall      (stall),
        .Busy       (busy)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    // Directed stimulus and checks, one step after another.
    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_rd = 2'd0; a_data = 16'h0000;
        b_valid = 1'b0; b_rd = 2'd0; b_data = 16'h0000;
        r1 = 2'd3; r2 = 2'd3;
        #2;
        check("rst_regwrite", {31'd0, reg_write}, 32'd0);
        check("rst_rd",       {30'd0, rd},        32'd0);
        check("rst_wdata",    {16'd0, wdata},     32'd0);
        check("rst_busy",     {31'd0, busy},      32'd0);
        check("rst_stall",    {31'd0, stall},     32'd0);
        check("rst_ready_a",  {31'd0, a_ready},   32'd1);
        check("rst_ready_b",  {31'd0, b_ready},   32'd1);
        // Requests presented during reset are not accepted.
        a_valid = 1'b1; a_rd = 2'd3; a_data = 16'hDEAD;
        tick();
        tick();
        a_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("rst_no_accept_busy", {31'd0, busy}, 32'd0);

        // Single A write.
        a_valid = 1'b1; a_rd = 2'd2; a_data = 16'h1234;
        tick();
        a_valid = 1'b0;
        check("single_c0_regwrite", {31'd0, reg_write}, 32'd0);
        check("single_c0_busy",     {31'd0, busy},      32'd1);
        check("single_c0_ready_a",  {31'd0, a_ready},   32'd1);
        tick();
        check("single_c1_regwrite", {31'd0, reg_write}, 32'd1);
        check("single_c1_rd",       {30'd0, rd},        32'd2);
        check("single_c1_wdata",    {16'd0, wdata},     32'h1234);
        check("single_c1_busy",     {31'd0, busy},      32'd1);
        tick();
        check("single_c2_regwrite", {31'd0, reg_write}, 32'd0);
        check("single_c2_busy",     {31'd0, busy},      32'd0);
        check("single_c2_rd_hold",  {30'd0, rd},        32'd2);
        check("single_c2_wd_hold",  {16'd0, wdata},     32'h1234);

        // Simultaneous first requests after reset: A wins, B one cycle later.
        reset_pulse();
        a_valid = 1'b1; a_rd = 2'd1; a_data = 16'h00AA;
        b_valid = 1'b1; b_rd = 2'd3; b_data = 16'h00BB;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check("sim_c0_ready_b",  {31'd0, b_ready},   32'd0);
        check("sim_c0_ready_a",  {31'd0, a_ready},   32'd1);
        check("sim_c0_regwrite", {31'd0, reg_write}, 32'd0);
        tick();
        check("sim_c1_regwrite", {31'd0, reg_write}, 32'd1);
        check("sim_c1_rd",       {30'd0, rd},        32'd1);
        check("sim_c1_wdata",    {16'd0, wdata},     32'h00AA);
        check("sim_c1_ready_b",  {31'd0, b_ready},   32'd1);
        tick();
        check("sim_c2_regwrite", {31'd0, reg_write}, 32'd1);
        check("sim_c2_rd",       {30'd0, rd},        32'd3);
        check("sim_c2_wdata",    {16'd0, wdata},     32'h00BB);
        tick();
        check("sim_c3_regwrite", {31'd0, reg_write}, 32'd0);
        check("sim_c3_busy",     {31'd0, busy},      32'd0);

        // Continuous contention: both valid for 6 edges, data advancing on accept.
        exp_data = '{16'hA000, 16'hB000, 16'hA001, 16'hB001, 16'hA002, 16'hB002, 16'hA003};
        exp_rd   = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
        reset_pulse();
        ia = 0;
        ib = 0;
        for (int k = 0; k < 6; k++) begin
            a_valid = 1'b1; a_rd = 2'd1; a_data = 16'(16'hA000 + ia);
            b_valid = 1'b1; b_rd = 2'd2; b_data = 16'(16'hB000 + ib);
            #1;
            ra = a_ready;
            rb = b_ready;
            tick();
            if (reg_write) begin
                got_data.push_back(wdata);
                got_rd.push_back(rd);
            end
            if (ra) ia++;
            if (rb) ib++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (reg_write) begin
                got_data.push_back(wdata);
                got_rd.push_back(rd);
            end
        end
        check("cont_accepted_a", ia, 32'd4);
        check("cont_accepted_b", ib, 32'd3);
        check("cont_write_count", got_data.size(), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < got_data.size()) begin
                check($sformatf("cont_data_%0d", i), {16'd0, got_data[i]}, {16'd0, exp_data[i]});
                check($sformatf("cont_rd_%0d", i),   {30'd0, got_rd[i]},   {30'd0, exp_rd[i]});
            end
        end

        // Read hazard on a pending B entry for Rd=0.
        b_valid = 1'b1; b_rd = 2'd0; b_data = 16'h5555;
        r1 = 2'd3; r2 = 2'd3;
        #1;
        check("haz_idle_stall", {31'd0, stall}, 32'd0);
        r1 = 2'd0;
        tick();
        b_valid = 1'b0;
        check("haz_pend_stall_r1", {31'd0, stall}, 32'd1);
        r1 = 2'd3; r2 = 2'd0;
        #1;
        check("haz_pend_stall_r2", {31'd0, stall}, 32'd1);
        r1 = 2'd0; r2 = 2'd3;
        tick();
        check("haz_issue_regwrite", {31'd0, reg_write}, 32'd1);
        check("haz_issue_stall",    {31'd0, stall},     32'd1);
        tick();
        check("haz_done_stall", {31'd0, stall}, 32'd0);
        r1 = 2'd1;
        #1;
        check("haz_nomatch_stall", {31'd0, stall}, 32'd0);

        // Reset in the middle of operation.
        a_valid = 1'b1; a_rd = 2'd1; a_data = 16'h1111;
        b_valid = 1'b1; b_rd = 2'd2; b_data = 16'h2222;
        tick();
        a_data = 16'h3333;
        b_valid = 1'b0;
        tick();
        a_valid = 1'b0;
        r1 = 2'd2; r2 = 2'd3;
        check("mid_pre_regwrite", {31'd0, reg_write}, 32'd1);
        check("mid_pre_stall",    {31'd0, stall},     32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_regwrite", {31'd0, reg_write}, 32'd0);
        check("mid_rst_rd",       {30'd0, rd},        32'd0);
        check("mid_rst_wdata",    {16'd0, wdata},     32'd0);
        check("mid_rst_busy",     {31'd0, busy},      32'd0);
        check("mid_rst_stall",    {31'd0, stall},     32'd0);
        check("mid_rst_ready_a",  {31'd0, a_ready},   32'd1);
        check("mid_rst_ready_b",  {31'd0, b_ready},   32'd1);
        rst = 1'b0;
        tick();
        check("mid_post1_regwrite", {31'd0, reg_write}, 32'd0);
        tick();
        check("mid_post2_regwrite", {31'd0, reg_write}, 32'd0);
        check("mid_post2_busy",     {31'd0, busy},      32'd0);
        a_valid = 1'b1; a_rd = 2'd3; a_data = 16'h7777;
        b_valid = 1'b1; b_rd = 2'd0; b_data = 16'h8888;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        check("mid_first_rd",    {30'd0, rd},    32'd3);
        check("mid_first_wdata", {16'd0, wdata}, 32'h7777);
        tick();
        check("mid_second_rd",    {30'd0, rd},    32'd0);
        check("mid_second_wdata", {16'd0, wdata}, 32'h8888);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
